pipeline_elastic: RTL

- Width/depth-parametrised delay pipeline with a per-stage valid bit and valid/ready backpressure.
- Bubbles collapse: an empty stage always accepts from the stage before it, even while the output is stalled.
- Optional input skid buffer registers the upstream ready, breaking the combinational ready chain.
- Sits between streaming producers and consumers, e.g. sensor video datapath and AXI-Stream glue, where the plain fixed-delay pipe cannot tolerate stalls.

---
 rtl/pipeline_elastic_pkg.sv | 14 +
 rtl/pipeline_skid.sv | 75 +++++++
 rtl/pipeline_elastic.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipeline_elastic_pkg.sv
// Shared types and helpers for the elastic pipeline and its input skid buffer.
package pipeline_elastic_pkg;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_e;

  // Occupancy counter width: must hold 0..PIPE_STAGES+1.
  function automatic int cnt_bits(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/pipeline_skid.sv
// Single-entry input skid buffer: registered upstream ready, in-order drain ahead of new input.
module pipeline_skid
  import pipeline_elastic_pkg::*;
#(
  parameter int PIPE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [PIPE_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [PIPE_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  skid_state_e           state_r;
  skid_state_e           state_nxt_s;
  logic [PIPE_WIDTH-1:0] buf_r;
  logic                  load_s;
  logic                  ready_s;

  // Next-state, stage-0 feed selection and ready decode
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    ready_s     = 1'b0;
    m_valid     = 1'b0;
    m_data      = s_data;
    case (state_r)
      SKID_EMPTY: begin
        ready_s = rstn & ~flush;
        m_valid = s_valid & ready_s;
        m_data  = s_data;
        if (s_valid && ready_s && !m_ready) begin
          state_nxt_s = SKID_FULL;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        m_valid = 1'b1;
        m_data  = buf_r;
        if (m_ready) begin
          state_nxt_s = SKID_EMPTY;
        end else begin
          state_nxt_s = SKID_FULL;
        end
      end
      default: begin
        state_nxt_s = SKID_EMPTY;
      end
    endcase
  end

  assign s_ready = ready_s;

  // Skid state and storage register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= SKID_EMPTY;
      buf_r   <= {PIPE_WIDTH{1'b0}};
    end else if (flush) begin
      state_r <= SKID_EMPTY;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        buf_r <= s_data;
      end
    end
  end

endmodule

// File: rtl/pipeline_elastic.sv
// Elastic delay pipeline: per-stage valid, valid/ready backpressure, bubble collapse, optional skid.
module pipeline_elastic
  import pipeline_elastic_pkg::*;
#(
  parameter int PIPE_WIDTH  = 32,
  parameter int PIPE_STAGES = 4,
  parameter int REG_READY   = 0,
  parameter int CNT_WIDTH   = cnt_bits(PIPE_STAGES)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [PIPE_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [PIPE_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  level
);

  localparam int LAST = PIPE_STAGES - 1;

  logic [PIPE_WIDTH-1:0]  stage_d_s [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stage_v_s;
  logic [PIPE_STAGES-1:0] adv_s;
  logic [PIPE_WIDTH-1:0]  feed_d_s;
  logic                   feed_v_s;
  logic                   ready_s;
  logic                   in_fire_s;
  logic                   out_fire_s;
  logic [CNT_WIDTH-1:0]   level_r;

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic                  v_r;
    logic [PIPE_WIDTH-1:0] d_r;
    logic                  src_v_s;
    logic [PIPE_WIDTH-1:0] src_d_s;

    if (k == 0) begin : g_head
      assign src_v_s = feed_v_s;
      assign src_d_s = feed_d_s;
    end else begin : g_body
      assign src_v_s = stage_v_s[k-1];
      assign src_d_s = stage_d_s[k-1];
    end

    // A stage may move when any stage between it and the output has a hole, or the output pops
    assign adv_s[k] = m_ready | ~(&stage_v_s[LAST:k]);

    // Stage register; data only toggles behind a valid source
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v_r <= 1'b0;
        d_r <= {PIPE_WIDTH{1'b0}};
      end else if (flush) begin
        v_r <= 1'b0;
      end else if (adv_s[k]) begin
        v_r <= src_v_s;
        if (src_v_s) begin
          d_r <= src_d_s;
        end
      end
    end

    assign stage_v_s[k] = v_r;
    assign stage_d_s[k] = d_r;
  end

  if (REG_READY != 0) begin : g_skid
    pipeline_skid #(
      .PIPE_WIDTH(PIPE_WIDTH)
    ) u_skid (
      .clk    (clk),
      .rstn   (rstn),
      .flush  (flush),
      .s_data (s_data),
      .s_valid(s_valid),
      .s_ready(ready_s),
      .m_data (feed_d_s),
      .m_valid(feed_v_s),
      .m_ready(adv_s[0])
    );
  end else begin : g_direct
    assign ready_s  = adv_s[0] & rstn & ~flush;
    assign feed_v_s = s_valid & ready_s;
    assign feed_d_s = s_data;
  end

  assign s_ready    = ready_s;
  assign m_valid    = stage_v_s[LAST];
  assign m_data     = stage_d_s[LAST];
  assign in_fire_s  = s_valid & ready_s;
  assign out_fire_s = m_valid & m_ready & ~flush;

  // Occupancy: beats inside stages plus skid; simultaneous push and pop cancel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_r <= {CNT_WIDTH{1'b0}};
    end else if (flush) begin
      level_r <= {CNT_WIDTH{1'b0}};
    end else begin
      case ({in_fire_s, out_fire_s})
        2'b10:   level_r <= level_r + CNT_WIDTH'(1);
        2'b01:   level_r <= level_r - CNT_WIDTH'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign level = level_r;

endmodule
